// File: rtl/audio_pdm_cic_receiver.sv
// Stereo PDM receiver. One interleaved PDM line is split on the ock edges:
// rising edges feed the left channel and falling edges feed the right channel.
// Each channel goes through a third-order CIC decimator (ratio DEC), and the
// result is presented as a 32-bit offset-binary pair on a valid/ready handshake.
module audio_pdm_cic_receiver #(
  parameter int unsigned DEC = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ock,
  input  logic        sdi,
  input  logic        en,
  output logic [31:0] dout_l,
  output logic [31:0] dout_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam int unsigned  L        = $clog2(DEC);
  localparam int unsigned  W        = 3 * L + 1;
  localparam int unsigned  SH       = 32 - 3 * L;
  localparam logic [L-1:0] CNT_LAST = L'(DEC - 1);

  // Per-channel CIC state. All arithmetic wraps modulo 2^W by design.
  typedef struct packed {
    logic [W-1:0] i1, i2, i3;
    logic [W-1:0] d1, d2, d3;
    logic [W-1:0] c3;
  } chan_t;

  // Pipelined integrator cascade: each stage adds the previous stage's old value.
  function automatic chan_t integrate(input chan_t s, input logic bit_in);
    chan_t r;
    r    = s;
    r.i1 = s.i1 + W'(bit_in);
    r.i2 = s.i2 + s.i1;
    r.i3 = s.i3 + s.i2;
    return r;
  endfunction

  // Three comb stages evaluated together; the delays capture each comb input.
  function automatic chan_t comb(input chan_t s);
    chan_t        r;
    logic [W-1:0] c1, c2;
    r    = s;
    c1   = s.i3 - s.d1;
    c2   = c1 - s.d2;
    r.c3 = c2 - s.d3;
    r.d1 = s.i3;
    r.d2 = c1;
    r.d3 = c2;
    return r;
  endfunction

  // Full-scale input gives exactly DEC^3, which alone sets bit 3L; clamp it.
  function automatic logic [31:0] map_out(input logic [W-1:0] c3);
    if (c3[3*L]) return 32'hFFFF_FFFF;
    return {c3[3*L-1:0], {SH{1'b0}}};
  endfunction

  logic         ock_d_q, ock_d_d, ock_dd_q, ock_dd_d;
  chan_t        l_q, l_d, r_q, r_d;
  logic [L-1:0] cnt_q, cnt_d;
  logic         frame_q, frame_d;
  logic [1:0]   warm_q, warm_d;
  logic         comb_vld_q, comb_vld_d;
  logic [31:0]  dout_l_q, dout_l_d, dout_r_q, dout_r_d;
  logic         out_valid_q, out_valid_d;
  logic         overrun_q, overrun_d;
  logic         ock_01, ock_10, frame_stb, load;

  // Next-state logic: edge detect, integrators, framing, comb step, handshake.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    ock_d_d     = ock;
    ock_dd_d    = ock_d_q;
    ock_01      = ~ock_dd_q & ock_d_q;
    ock_10      = ock_dd_q & ~ock_d_q;
    frame_stb   = ock_10 && (cnt_q == CNT_LAST);
    l_d         = l_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    frame_d     = frame_stb;
    warm_d      = warm_q;
    comb_vld_d  = 1'b0;
    dout_l_d    = dout_l_q;
    dout_r_d    = dout_r_q;
    load        = comb_vld_q;

    if (ock_01) l_d = integrate(l_q, sdi);
    if (ock_10) begin
      r_d   = integrate(r_q, sdi);
      cnt_d = cnt_q + L'(1);
    end

    // Comb runs one clk after the frame strobe; ock phases are long enough
    // that no channel strobe can coincide with it.
    if (frame_q) begin
      l_d        = comb(l_d);
      r_d        = comb(r_d);
      comb_vld_d = (warm_q == 2'd3);
      if (warm_q != 2'd3) warm_d = warm_q + 2'd1;
    end

    if (load) begin
      dout_l_d = map_out(l_q.c3);
      dout_r_d = map_out(r_q.c3);
    end
    out_valid_d = load | (out_valid_q & ~out_ready);
    overrun_d   = load & out_valid_q & ~out_ready;

    // Disabled: the whole datapath is parked at zero and the output drops.
    if (!en) begin
      l_d         = '0;
      r_d         = '0;
      cnt_d       = '0;
      frame_d     = 1'b0;
      warm_d      = '0;
      comb_vld_d  = 1'b0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // Two-flop synchroniser for ock; it keeps running even while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (!rstn) begin
      ock_d_q  <= 1'b0;
      ock_dd_q <= 1'b0;
    end else begin
      ock_d_q  <= ock_d_d;
      ock_dd_q <= ock_dd_d;
    end
  end

  // Datapath and handshake state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      l_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      frame_q     <= 1'b0;
      warm_q      <= '0;
      comb_vld_q  <= 1'b0;
      dout_l_q    <= 32'h8000_0000;
      dout_r_q    <= 32'h8000_0000;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      l_q         <= l_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      warm_q      <= warm_d;
      comb_vld_q  <= comb_vld_d;
      dout_l_q    <= dout_l_d;
      dout_r_q    <= dout_r_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dout_l    = dout_l_q;
  assign dout_r    = dout_r_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_pdm_cic_receiver.sv
// Self-checking bench for audio_pdm_cic_receiver (DEC = 64). The reference
// model keeps every PDM bit per channel and computes each frame's CIC output
// in closed form: integrator i3 after n bits is sum x_j*C(n-1-j,2), and the
// comb output is the third backward difference of i3 taken at frame ends.
module tb_audio_pdm_cic_receiver;

  localparam int     DEC  = 64;
  localparam int     L    = 6;
  localparam int     W    = 3 * L + 1;
  localparam int     SH   = 32 - 3 * L;
  localparam int     HALF = 5;
  localparam longint MOD  = longint'(1) << W;
  localparam longint FULL = longint'(1) << (3 * L);

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ock = 1'b0;
  logic        sdi = 1'b0;
  logic        en = 1'b1;
  logic        out_ready = 1'b1;
  logic [31:0] dout_l, dout_r;
  logic        out_valid, overrun;

  audio_pdm_cic_receiver #(.DEC(DEC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ock       (ock),
    .sdi       (sdi),
    .en        (en),
    .dout_l    (dout_l),
    .dout_r    (dout_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  pair_t       exp_q[$];
  bit          samp_l[$];
  bit          samp_r[$];
  longint      hist_l[$];
  longint      hist_r[$];
  int          nfall;
  bit          dir_on;
  logic [31:0] dir_l, dir_r;
  bit          auto_chk;
  int          pairs_seen;
  int          m_pulses;
  bit          m_seen, m_fell;
  logic [31:0] m_ovr_dl, m_ovr_dr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic longint i3_of(input bit right);
    longint n, acc;
    bit     x;
    acc = 0;
    n   = right ? samp_r.size() : samp_l.size();
    for (int j = 0; j < n; j++) begin
      x = right ? samp_r[j] : samp_l[j];
      if (x) acc += (n - 1 - j) * (n - 2 - j) / 2;
    end
    return acc;
  endfunction

  function automatic logic [31:0] to_dout(input longint h0, input longint h1,
                                          input longint h2, input longint h3);
    longint c;
    c = h0 - 3 * h1 + 3 * h2 - h3;
    c = ((c % MOD) + MOD) % MOD;
    if (c >= FULL) return 32'hFFFF_FFFF;
    return 32'(c << SH);
  endfunction

  task automatic model_clear();
    samp_l.delete();
    samp_r.delete();
    hist_l.delete();
    hist_r.delete();
    hist_l.push_back(0);
    hist_r.push_back(0);
    nfall = 0;
    exp_q.delete();
  endtask

  // Drive one ock edge with its data bit and let the model record it.
  task automatic drive_edge(input logic lvl, input logic b);
    int    f;
    pair_t p;
    ock = lvl;
    sdi = b;
    if (rstn && en) begin
      if (lvl) samp_l.push_back(b);
      else begin
        samp_r.push_back(b);
        nfall++;
        if (nfall % DEC == 0) begin
          hist_l.push_back(i3_of(1'b0));
          hist_r.push_back(i3_of(1'b1));
          f = nfall / DEC;
          if (f >= 4) begin
            if (dir_on) begin
              p.l = dir_l;
              p.r = dir_r;
            end else begin
              p.l = to_dout(hist_l[f], hist_l[f-1], hist_l[f-2], hist_l[f-3]);
              p.r = to_dout(hist_r[f], hist_r[f-1], hist_r[f-2], hist_r[f-3]);
            end
            exp_q.push_back(p);
          end
        end
      end
    end
  endtask

  // Advance one clk and observe outputs on the falling edge.
  task automatic tick();
    pair_t p;
    @(negedge clk);
    if (auto_chk) begin
      check("overrun_idle", 32'(overrun), 32'd0);
      if (out_valid === 1'b1) begin
        pairs_seen++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_valid: observed out_valid=1 dout_l=%h dout_r=%h, expected no pair", dout_l, dout_r);
        end
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          check("dout_l", dout_l, p.l);
          check("dout_r", dout_r, p.r);
        end
      end
    end else begin
      if (overrun === 1'b1) begin
        m_pulses++;
        m_ovr_dl = dout_l;
        m_ovr_dr = dout_r;
      end
      if (out_valid === 1'b1) m_seen = 1'b1;
      else if (m_seen) m_fell = 1'b1;
    end
  endtask

  task automatic ock_period(input logic bl, input logic br);
    drive_edge(1'b1, bl);
    repeat (HALF) tick();
    drive_edge(1'b0, br);
    repeat (HALF) tick();
  endtask

  // kind: 0 all ones, 1 left=1/right=0, 2 alternating 1,0, 3 random, 4 all zeros
  task automatic run_frames(input int nf, input int kind);
    for (int k = 0; k < nf * DEC; k++) begin
      case (kind)
        0:       ock_period(1'b1, 1'b1);
        1:       ock_period(1'b1, 1'b0);
        2:       ock_period(k % 2 == 0, k % 2 == 0);
        3:       ock_period(1'($urandom), 1'($urandom));
        default: ock_period(1'b0, 1'b0);
      endcase
    end
  endtask

  task automatic reset_pulse();
    tick();
    rstn = 1'b0;
    model_clear();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    pairs_seen = 0;
  endtask

  task automatic manual_start();
    auto_chk = 1'b0;
    m_pulses = 0;
    m_seen   = 1'b0;
    m_fell   = 1'b0;
    m_ovr_dl = '0;
    m_ovr_dr = '0;
  endtask

  initial begin
    pair_t e1, e2;
    auto_chk   = 1'b1;
    dir_on     = 1'b0;
    dir_l      = '0;
    dir_r      = '0;
    pairs_seen = 0;
    model_clear();

    // Reset state
    #3 rstn = 1'b0;
    tick();
    tick();
    check("rst_dout_l", dout_l, 32'h8000_0000);
    check("rst_dout_r", dout_r, 32'h8000_0000);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    tick();

    // Constant ones: full-scale pairs from frame 4
    dir_on = 1'b1; dir_l = 32'hFFFF_FFFF; dir_r = 32'hFFFF_FFFF;
    run_frames(6, 0);
    check("ones_pairs", 32'(pairs_seen), 32'd3);
    check("ones_pending", 32'(exp_q.size()), 32'd0);
    reset_pulse();

    // Left ones, right zeros
    dir_l = 32'hFFFF_FFFF; dir_r = 32'h0000_0000;
    run_frames(6, 1);
    check("lr_pairs", 32'(pairs_seen), 32'd3);
    reset_pulse();

    // Alternating bits on both channels: exactly midscale
    dir_l = 32'h8000_0000; dir_r = 32'h8000_0000;
    run_frames(6, 2);
    check("alt_pairs", 32'(pairs_seen), 32'd3);
    reset_pulse();

    // Random bits against the closed-form model
    dir_on = 1'b0;
    run_frames(7, 3);
    check("rnd_pairs", 32'(pairs_seen), 32'd4);

    // Back-pressure across two loads
    out_ready = 1'b0;
    manual_start();
    run_frames(2, 3);
    check("hs_valid_held", 32'(out_valid), 32'd1);
    check("hs_valid_no_drop", 32'(m_fell), 32'd0);
    check("hs_overrun_pulses", 32'(m_pulses), 32'd1);
    n_cmp++;
    assert (exp_q.size() == 2) else begin
      n_bad++;
      $error("FAIL hs_model_frames: observed %0d queued frames, expected 2", exp_q.size());
    end
    if (exp_q.size() == 2) begin
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      check("hs_dout_l", dout_l, e2.l);
      check("hs_dout_r", dout_r, e2.r);
      check("hs_ovr_dout_l", m_ovr_dl, e2.l);
      check("hs_ovr_dout_r", m_ovr_dr, e2.r);
    end
    out_ready = 1'b1;
    auto_chk  = 1'b1;
    tick();
    check("hs_valid_fell", 32'(out_valid), 32'd0);

    // Reset mid-frame at count 31 with a pair held
    out_ready = 1'b0;
    manual_start();
    run_frames(1, 3);
    for (int k = 0; k < 31; k++) ock_period(1'($urandom), 1'($urandom));
    tick();
    tick();
    check("rmid_valid_before", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    model_clear();
    #1;
    check("rmid_dout_l", dout_l, 32'h8000_0000);
    check("rmid_dout_r", dout_r, 32'h8000_0000);
    check("rmid_valid", 32'(out_valid), 32'd0);
    check("rmid_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    rstn       = 1'b1;
    out_ready  = 1'b1;
    auto_chk   = 1'b1;
    pairs_seen = 0;
    run_frames(6, 3);
    check("rmid_pairs", 32'(pairs_seen), 32'd3);
    check("rmid_pending", 32'(exp_q.size()), 32'd0);

    // Enable dropped for 10 clk, then constant zeros
    out_ready = 1'b0;
    manual_start();
    run_frames(1, 3);
    check("en_valid_before", 32'(out_valid), 32'd1);
    drive_edge(1'b1, 1'b0);
    tick();
    tick();
    en = 1'b0;
    tick();
    check("en_valid_cleared", 32'(out_valid), 32'd0);
    check("en_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    drive_edge(1'b0, 1'b0);
    repeat (HALF) tick();
    drive_edge(1'b1, 1'b0);
    tick();
    tick();
    en = 1'b1;
    model_clear();
    dir_on = 1'b1; dir_l = 32'h0000_0000; dir_r = 32'h0000_0000;
    out_ready  = 1'b1;
    auto_chk   = 1'b1;
    pairs_seen = 0;
    tick();
    tick();
    tick();
    drive_edge(1'b0, 1'b0);
    repeat (HALF) tick();
    while (nfall < 6 * DEC) ock_period(1'b0, 1'b0);
    check("en_pairs", 32'(pairs_seen), 32'd3);
    check("en_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
